// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL loop controller: loop-state encoding, divider and
// statistics widths, and small arithmetic helpers.
package adpll_pkg;

  localparam logic [1:0] LS_IDLE    = 2'd0;
  localparam logic [1:0] LS_ACQUIRE = 2'd1;
  localparam logic [1:0] LS_TRACK   = 2'd2;
  localparam logic [1:0] LS_LOCKED  = 2'd3;

  localparam int DIV_MIN = 4;
  localparam int DIV_W   = 8;
  localparam int STAT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = LS_IDLE,
    ST_ACQUIRE = LS_ACQUIRE,
    ST_TRACK   = LS_TRACK,
    ST_LOCKED  = LS_LOCKED
  } loop_state_e;

  // The divider cannot run below DIV_MIN, so smaller requests are raised to it.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] req);
    if (req < DIV_W'(DIV_MIN)) begin
      return DIV_W'(DIV_MIN);
    end else begin
      return req;
    end
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
    if (val == {STAT_W{1'b1}}) begin
      return val;
    end else begin
      return val + STAT_W'(1'b1);
    end
  endfunction

endpackage

// File: rtl/adpll_rw_filter.sv
// Random-walk filter: saturating signed accumulator of lead/lag samples with a
// threshold-hit flag computed on the post-sample value.
module adpll_rw_filter
  import adpll_pkg::*;
#(
  parameter int AccW = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clr,
  input  logic            i_sample,
  input  logic            i_up,
  input  logic            i_down,
  input  logic [AccW-1:0] i_thr,
  output logic            o_hit_pos,
  output logic            o_hit_neg
);

  localparam logic signed [AccW-1:0] ACC_ONE = AccW'(1'b1);

  logic signed [AccW-1:0] r_acc;
  logic signed [AccW-1:0] w_acc_nxt;
  logic signed [AccW-1:0] w_thr_pos;
  logic signed [AccW-1:0] w_thr_neg;

  assign w_thr_pos = $signed(i_thr);
  assign w_thr_neg = -$signed(i_thr);

  // Step towards the sample direction, holding at +/-threshold.
  always_comb begin
    w_acc_nxt = r_acc;
    if (i_sample && i_up && !i_down) begin
      if (r_acc < w_thr_pos) begin
        w_acc_nxt = r_acc + ACC_ONE;
      end else begin
        w_acc_nxt = w_thr_pos;
      end
    end else if (i_sample && i_down && !i_up) begin
      if (r_acc > w_thr_neg) begin
        w_acc_nxt = r_acc - ACC_ONE;
      end else begin
        w_acc_nxt = w_thr_neg;
      end
    end else begin
      w_acc_nxt = r_acc;
    end
  end

  assign o_hit_pos = (w_acc_nxt == w_thr_pos);
  assign o_hit_neg = (w_acc_nxt == w_thr_neg);

  // Accumulator register; a clear discards the current sample as well.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_nxt;
    end
  end

endmodule

// File: rtl/adpll_phase_ctrl.sv
// ADPLL loop controller: acquisition/track/lock sequencing, correction pulses with hold-off,
// DividerMax ownership. Define ADPLL_CORR_STATS_EN to add PosCount/NegCount pulse counters.
module adpll_phase_ctrl
  import adpll_pkg::*;
#(
  parameter int TrackThresh = 8,
  parameter int AcqThresh   = 2,
  parameter int HoldOff     = 4,
  parameter int AcqQuiet    = 8,
  parameter int LockCount   = 32,
  parameter int DivDefault  = 48
) (
  input  logic             MainClock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             PdValid,
  input  logic             Lead,
  input  logic             Lag,
  input  logic             ConfigLoad,
  input  logic [DIV_W-1:0] DividerMaxIn,
  output logic             Positive,
  output logic             Negative,
  output logic [DIV_W-1:0] DividerMax,
  output logic             Locked,
  output logic [1:0]       LoopState
`ifdef ADPLL_CORR_STATS_EN
  ,
  output logic [STAT_W-1:0] PosCount,
  output logic [STAT_W-1:0] NegCount
`endif
);

  localparam int ACC_W   = $clog2(TrackThresh) + 2;
  localparam int HOLD_W  = $clog2(HoldOff + 2);
  localparam int CNT_MAX = (LockCount > AcqQuiet) ? LockCount : AcqQuiet;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  loop_state_e       r_state;
  loop_state_e       w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [DIV_W-1:0]  r_div;
  logic              r_pos;
  logic              r_neg;
  logic              r_locked;
  logic              w_fire_pos;
  logic              w_fire_neg;
  logic              w_fire;
  logic              w_acc_clr;
  logic              w_hit_pos;
  logic              w_hit_neg;
  logic              w_quiet;
  logic [ACC_W-1:0]  w_thr;

  assign w_quiet = (Lead == Lag);
  assign w_thr   = (r_state == ST_ACQUIRE) ? ACC_W'(AcqThresh) : ACC_W'(TrackThresh);
  assign w_fire  = w_fire_pos | w_fire_neg;

  adpll_rw_filter #(.AccW(ACC_W)) u_filter (
    .i_clk     (MainClock),
    .i_rst     (Reset),
    .i_clr     (w_acc_clr),
    .i_sample  (PdValid),
    .i_up      (Lead),
    .i_down    (Lag),
    .i_thr     (w_thr),
    .o_hit_pos (w_hit_pos),
    .o_hit_neg (w_hit_neg)
  );

  // Loop sequencing; r_cnt counts quiet samples in ACQUIRE and samples since the last
  // correction in TRACK/LOCKED (parked at LockCount on LOCKED entry = no recent correction).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire_pos  = 1'b0;
    w_fire_neg  = 1'b0;
    w_acc_clr   = 1'b0;
    if (!Enable) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_acc_clr   = 1'b1;
    end else begin
      w_fire_neg = (r_state != ST_IDLE) && (r_hold == '0) && w_hit_pos;
      w_fire_pos = (r_state != ST_IDLE) && (r_hold == '0) && w_hit_neg;
      w_acc_clr  = w_fire_neg | w_fire_pos;
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ACQUIRE;
          w_cnt_nxt   = '0;
          w_acc_clr   = 1'b1;
        end
        ST_ACQUIRE: begin
          if (PdValid && !w_quiet) begin
            w_cnt_nxt = '0;
          end else if (PdValid && (r_cnt == CNT_W'(AcqQuiet - 1))) begin
            w_state_nxt = ST_TRACK;
            w_cnt_nxt   = '0;
            w_acc_clr   = 1'b1;
          end else if (PdValid) begin
            w_cnt_nxt = r_cnt + CNT_W'(1'b1);
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        ST_TRACK: begin
          if (w_fire) begin
            w_cnt_nxt = '0;
          end else if (PdValid && (r_cnt == CNT_W'(LockCount - 1))) begin
            w_state_nxt = ST_LOCKED;
            w_cnt_nxt   = CNT_W'(LockCount);
          end else if (PdValid) begin
            w_cnt_nxt = r_cnt + CNT_W'(1'b1);
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        ST_LOCKED: begin
          if (w_fire && (r_cnt < CNT_W'(LockCount))) begin
            w_state_nxt = ST_TRACK;
            w_cnt_nxt   = '0;
          end else if (w_fire) begin
            w_cnt_nxt = '0;
          end else if (PdValid && (r_cnt != CNT_W'(LockCount))) begin
            w_cnt_nxt = r_cnt + CNT_W'(1'b1);
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_acc_clr   = 1'b1;
        end
      endcase
    end
  end

  // State, counters, pulse outputs and divider configuration.
  always_ff @(posedge MainClock or posedge Reset) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hold   <= '0;
      r_pos    <= 1'b0;
      r_neg    <= 1'b0;
      r_locked <= 1'b0;
      r_div    <= DIV_W'(DivDefault);
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pos    <= w_fire_pos;
      r_neg    <= w_fire_neg;
      r_locked <= (w_state_nxt == ST_LOCKED);
      if (!Enable || (r_state == ST_IDLE)) begin
        r_hold <= '0;
      end else if (w_fire) begin
        r_hold <= HOLD_W'(HoldOff);
      end else if (r_hold != '0) begin
        r_hold <= r_hold - HOLD_W'(1'b1);
      end else begin
        r_hold <= r_hold;
      end
      if (ConfigLoad && (r_state == ST_IDLE)) begin
        r_div <= clamp_div(DividerMaxIn);
      end else begin
        r_div <= r_div;
      end
    end
  end

  assign Positive   = r_pos;
  assign Negative   = r_neg;
  assign DividerMax = r_div;
  assign Locked     = r_locked;
  assign LoopState  = r_state;

`ifdef ADPLL_CORR_STATS_EN
  logic [STAT_W-1:0] r_pos_cnt;
  logic [STAT_W-1:0] r_neg_cnt;
  logic              w_acq_entry;

  assign w_acq_entry = (r_state == ST_IDLE) && (w_state_nxt == ST_ACQUIRE);

  // Issued-pulse counters, restarted on each new acquisition.
  always_ff @(posedge MainClock or posedge Reset) begin
    if (Reset) begin
      r_pos_cnt <= '0;
      r_neg_cnt <= '0;
    end else if (w_acq_entry) begin
      r_pos_cnt <= '0;
      r_neg_cnt <= '0;
    end else begin
      r_pos_cnt <= w_fire_pos ? sat_inc(r_pos_cnt) : r_pos_cnt;
      r_neg_cnt <= w_fire_neg ? sat_inc(r_neg_cnt) : r_neg_cnt;
    end
  end

  assign PosCount = r_pos_cnt;
  assign NegCount = r_neg_cnt;
`endif

endmodule

// File: tb/tb_adpll_phase_ctrl.sv
// Directed bench for adpll_phase_ctrl: vector table for config/acquisition/hold-off,
// hand sequences for lock entry/exit, reset mid-pulse and enable drop.
module tb_adpll_phase_ctrl;

  logic       MainClock = 1'b0;
  logic       Reset;
  logic       Enable;
  logic       PdValid;
  logic       Lead;
  logic       Lag;
  logic       ConfigLoad;
  logic [7:0] DividerMaxIn;
  logic       Positive;
  logic       Negative;
  logic [7:0] DividerMax;
  logic       Locked;
  logic [1:0] LoopState;
`ifdef ADPLL_CORR_STATS_EN
  logic [15:0] PosCount;
  logic [15:0] NegCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 MainClock = ~MainClock;

  adpll_phase_ctrl dut (
    .MainClock    (MainClock),
    .Reset        (Reset),
    .Enable       (Enable),
    .PdValid      (PdValid),
    .Lead         (Lead),
    .Lag          (Lag),
    .ConfigLoad   (ConfigLoad),
    .DividerMaxIn (DividerMaxIn),
    .Positive     (Positive),
    .Negative     (Negative),
    .DividerMax   (DividerMax),
    .Locked       (Locked),
    .LoopState    (LoopState)
`ifdef ADPLL_CORR_STATS_EN
    ,
    .PosCount     (PosCount),
    .NegCount     (NegCount)
`endif
  );

  typedef struct {
    logic       en, v, ld, lg, cl;
    logic [7:0] din;
    logic       pos, neg;
    logic [1:0] st;
    logic [7:0] dmax;
    logic       lk;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic v, input logic ld, input logic lg,
                              input logic cl, input logic [7:0] din, input logic pos,
                              input logic neg, input logic [1:0] st, input logic [7:0] dmax,
                              input logic lk);
    vec_t r;
    r.en = en; r.v = v; r.ld = ld; r.lg = lg; r.cl = cl; r.din = din;
    r.pos = pos; r.neg = neg; r.st = st; r.dmax = dmax; r.lk = lk;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge MainClock);
    #1;
  endtask

  task automatic drive(input logic en, input logic v, input logic ld, input logic lg);
    Enable = en; PdValid = v; Lead = ld; Lag = lg;
  endtask

  initial begin
    int first_pos;
    int last_pos;
    int n_pos;
    int n_both;

    // row: en v ld lg cl din | pos neg st div lk
    tbl.push_back(mk(0,0,0,0,1,8'd2,   0,0,0,8'd4,0));   // clamp to 4
    tbl.push_back(mk(0,0,0,0,1,8'd100, 0,0,0,8'd100,0));
    tbl.push_back(mk(1,0,0,0,1,8'd50,  0,0,1,8'd50,0));  // load + enable same edge
    tbl.push_back(mk(1,1,1,0,0,8'd0,   0,0,1,8'd50,0));
    tbl.push_back(mk(1,1,1,0,0,8'd0,   0,1,1,8'd50,0));  // 2nd lead -> Negative
    tbl.push_back(mk(1,1,1,0,0,8'd0,   0,0,1,8'd50,0));
    tbl.push_back(mk(1,1,1,0,0,8'd0,   0,0,1,8'd50,0));  // threshold hit in hold-off
    tbl.push_back(mk(1,1,1,0,0,8'd0,   0,0,1,8'd50,0));
    tbl.push_back(mk(1,0,0,0,0,8'd0,   0,0,1,8'd50,0));
    tbl.push_back(mk(1,0,0,0,0,8'd0,   0,1,1,8'd50,0));  // fires right after expiry
    tbl.push_back(mk(1,1,0,1,0,8'd0,   0,0,1,8'd50,0));
    tbl.push_back(mk(1,1,0,1,0,8'd0,   0,0,1,8'd50,0));
    tbl.push_back(mk(1,0,0,0,0,8'd0,   0,0,1,8'd50,0));
    tbl.push_back(mk(1,0,0,0,0,8'd0,   0,0,1,8'd50,0));
    tbl.push_back(mk(1,0,0,0,0,8'd0,   1,0,1,8'd50,0));  // Positive after hold-off
    tbl.push_back(mk(1,0,0,0,0,8'd0,   0,0,1,8'd50,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1,1,0,0,0,8'd0, 0,0,1,8'd50,0));
    tbl.push_back(mk(1,1,1,0,0,8'd0,   0,0,1,8'd50,0));  // breaks the quiet run
    for (int i = 0; i < 7; i++) tbl.push_back(mk(1,1,0,0,0,8'd0, 0,0,1,8'd50,0));
    tbl.push_back(mk(1,1,1,1,0,8'd0,   0,0,2,8'd50,0));  // 8th quiet -> TRACK

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ConfigLoad = 1'b0; DividerMaxIn = 8'd0; Reset = 1'b1;
    step(); step();
    chk("rst_pos", {15'd0, Positive}, 16'd0);
    chk("rst_neg", {15'd0, Negative}, 16'd0);
    chk("rst_state", {14'd0, LoopState}, 16'd0);
    chk("rst_div", {8'd0, DividerMax}, 16'd48);
    chk("rst_lock", {15'd0, Locked}, 16'd0);
    Reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].v, tbl[i].ld, tbl[i].lg);
      ConfigLoad = tbl[i].cl; DividerMaxIn = tbl[i].din;
      step();
      chk($sformatf("row%0d_pos", i), {15'd0, Positive}, {15'd0, tbl[i].pos});
      chk($sformatf("row%0d_neg", i), {15'd0, Negative}, {15'd0, tbl[i].neg});
      chk($sformatf("row%0d_state", i), {14'd0, LoopState}, {14'd0, tbl[i].st});
      chk($sformatf("row%0d_div", i), {8'd0, DividerMax}, {8'd0, tbl[i].dmax});
      chk($sformatf("row%0d_lock", i), {15'd0, Locked}, {15'd0, tbl[i].lk});
    end
`ifdef ADPLL_CORR_STATS_EN
    chk("stat_neg_acq", NegCount, 16'd2);
    chk("stat_pos_acq", PosCount, 16'd1);
`endif

    // ConfigLoad outside IDLE is ignored
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    ConfigLoad = 1'b1; DividerMaxIn = 8'd60;
    step();
    ConfigLoad = 1'b0;
    chk("cfg_track_div", {8'd0, DividerMax}, 16'd50);
    chk("cfg_track_state", {14'd0, LoopState}, 16'd2);

    // Two batches of 8 Lag strobes every other cycle in TRACK
    n_pos = 0; n_both = 0; first_pos = -1; last_pos = -1;
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, (k % 2) == 0, 1'b0, 1'b1);
      step();
      if (Positive && Negative) n_both++;
      if (Negative) n_both++;
      if (Positive) begin
        n_pos++;
        if (first_pos < 0) first_pos = k;
        else last_pos = k;
      end
    end
    chk("trk_pos_count", 16'(n_pos), 16'd2);
    chk("trk_first_pos", 16'(first_pos), 16'd14);
    chk("trk_spacing", 16'(last_pos - first_pos), 16'd16);
    chk("trk_no_neg", 16'(n_both), 16'd0);

    // 32 quiet strobes without a correction -> LOCKED on the 32nd
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      step();
      if (k == 30) chk("lock_31_state", {14'd0, LoopState}, 16'd2);
      if (k == 31) begin
        chk("lock_32_state", {14'd0, LoopState}, 16'd3);
        chk("lock_32_locked", {15'd0, Locked}, 16'd1);
      end
    end

    // First correction keeps LOCKED; second within the window drops to TRACK
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      step();
      if (k == 7) begin
        chk("lk_corr1_neg", {15'd0, Negative}, 16'd1);
        chk("lk_corr1_state", {14'd0, LoopState}, 16'd3);
      end
      if (k == 14) chk("lk_pre2_state", {14'd0, LoopState}, 16'd3);
      if (k == 15) begin
        chk("lk_corr2_neg", {15'd0, Negative}, 16'd1);
        chk("lk_corr2_state", {14'd0, LoopState}, 16'd2);
        chk("lk_corr2_locked", {15'd0, Locked}, 16'd0);
      end
    end
`ifdef ADPLL_CORR_STATS_EN
    chk("stat_neg_all", NegCount, 16'd4);
    chk("stat_pos_all", PosCount, 16'd3);
`endif

    // Asynchronous reset while Negative is high
    Reset = 1'b1;
    #1;
    chk("rstmid_neg", {15'd0, Negative}, 16'd0);
    chk("rstmid_state", {14'd0, LoopState}, 16'd0);
    chk("rstmid_div", {8'd0, DividerMax}, 16'd48);
    chk("rstmid_locked", {15'd0, Locked}, 16'd0);
`ifdef ADPLL_CORR_STATS_EN
    chk("rstmid_negcnt", NegCount, 16'd0);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    Reset = 1'b0;

    // Re-enable, one Negative, drop Enable, re-enable again
    drive(1'b1, 1'b0, 1'b0, 1'b0); step();
    chk("en_state", {14'd0, LoopState}, 16'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0); step();
    drive(1'b1, 1'b1, 1'b1, 1'b0); step();
    chk("en_neg", {15'd0, Negative}, 16'd1);
`ifdef ADPLL_CORR_STATS_EN
    chk("en_negcnt", NegCount, 16'd1);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0); step();
    chk("dis_state", {14'd0, LoopState}, 16'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0); step();
    chk("reen_state", {14'd0, LoopState}, 16'd1);
`ifdef ADPLL_CORR_STATS_EN
    chk("reen_negcnt", NegCount, 16'd0);
    chk("reen_poscnt", PosCount, 16'd0);
`endif

    // Enable drops on the cycle a pulse would issue: pulse suppressed
    drive(1'b1, 1'b1, 1'b1, 1'b0); step();
    drive(1'b0, 1'b1, 1'b1, 1'b0); step();
    chk("supp_neg", {15'd0, Negative}, 16'd0);
    chk("supp_state", {14'd0, LoopState}, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
